mdio_responder: RTL and testbench

- Clause-22 MDIO management responder (PHY-side end of the management bus); counterpart of the team's AXI-driven MDIO master.
- Decodes frames on mdc/mdio, holds an internal 32 x 16-bit PHY register file, and drives read data back on the split tri-state pins (mdio_i/mdio_o/mdio_t).
- Used as a PHY model in loopback/self-test builds and benches.
- Host-side config port preloads registers; every MDIO write is reported on a notification port.

---
 rtl/mdio_responder_if.sv | 26 ++
 rtl/mdio_responder.sv | 192 +++++++++++++++++++
 tb/tb_mdio_responder.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/mdio_responder_if.sv
// Management-bus bundle for the MDIO responder: pad pins, host config port,
// and the write-notification port.
interface mdio_responder_if;
  logic        mdc;
  logic        mdio_i;
  logic        mdio_o;
  logic        mdio_t;
  logic        cfg_we;
  logic [4:0]  cfg_addr;
  logic [15:0] cfg_wdata;
  logic        wr_valid;
  logic [4:0]  wr_addr;
  logic [15:0] wr_data;

  // Bus master / host side (bench, station management logic).
  modport master (
    output mdc, mdio_i, cfg_we, cfg_addr, cfg_wdata,
    input  mdio_o, mdio_t, wr_valid, wr_addr, wr_data
  );

  // PHY side (the responder).
  modport slave (
    input  mdc, mdio_i, cfg_we, cfg_addr, cfg_wdata,
    output mdio_o, mdio_t, wr_valid, wr_addr, wr_data
  );
endinterface

// File: rtl/mdio_responder.sv
// Clause-22 MDIO responder: decodes frames sampled on mdc rising edges,
// serves a 32 x 16 register file and reports every accepted MDIO write.
module mdio_responder #(
  parameter logic [4:0]  PHY_ADDR     = 5'd1,
  parameter int unsigned PREAMBLE_LEN = 32,
  parameter logic [15:0] ID1          = 16'h0000,
  parameter logic [15:0] ID2          = 16'h0000
) (
  input logic            clk,
  input logic            rst,
  mdio_responder_if.slave bus
);

  localparam int unsigned PW      = $clog2(PREAMBLE_LEN + 1);
  localparam logic [PW-1:0] PRE_MAX = PW'(PREAMBLE_LEN);

  typedef enum logic [3:0] {
    S_IDLE, S_ST1, S_OP1, S_OP2, S_PHYAD, S_REGAD, S_TA1, S_TA2, S_DATA
  } state_t;

  state_t        state, state_nxt;
  logic [2:0]    mdc_s;
  logic [1:0]    mdio_s;
  logic [PW-1:0] pre_cnt, pre_nxt;
  logic [3:0]    cnt, cnt_nxt;
  logic          op_hi, op_hi_nxt;
  logic          op_rd, op_rd_nxt;
  logic [4:0]    phyad, phyad_nxt;
  logic [4:0]    regad, regad_nxt;
  logic [15:0]   shreg, shreg_nxt;
  logic          mdio_o_nxt, mdio_t_nxt;
  logic          commit_c;
  logic [15:0]   regs [32];

  logic mdc_rise, bit_in;
  assign mdc_rise = mdc_s[1] & ~mdc_s[2];
  assign bit_in   = mdio_s[1];

  // Two-flop synchronisers, third mdc stage for rising-edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      mdc_s  <= '0;
      mdio_s <= '1;
    end else begin
      mdc_s  <= {mdc_s[1:0], bus.mdc};
      mdio_s <= {mdio_s[0], bus.mdio_i};
    end
  end

  // Frame decode: next state, shift registers and next pad drive.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    op_hi_nxt  = op_hi;
    op_rd_nxt  = op_rd;
    phyad_nxt  = phyad;
    regad_nxt  = regad;
    shreg_nxt  = shreg;
    mdio_o_nxt = bus.mdio_o;
    mdio_t_nxt = bus.mdio_t;
    commit_c   = 1'b0;
    pre_nxt    = pre_cnt;
    if (mdc_rise) begin
      unique case (state)
        S_IDLE: if (!bit_in && pre_cnt == PRE_MAX) state_nxt = S_ST1;
        S_ST1:  state_nxt = bit_in ? S_OP1 : S_IDLE;
        S_OP1: begin
          op_hi_nxt = bit_in;
          state_nxt = S_OP2;
        end
        S_OP2: begin
          if (op_hi != bit_in) begin
            op_rd_nxt = op_hi;
            cnt_nxt   = 4'd4;
            state_nxt = S_PHYAD;
          end else begin
            state_nxt = S_IDLE;
          end
        end
        S_PHYAD: begin
          phyad_nxt = {phyad[3:0], bit_in};
          if (cnt == 4'd0) begin
            cnt_nxt   = 4'd4;
            state_nxt = S_REGAD;
          end else begin
            cnt_nxt = cnt - 4'd1;
          end
        end
        S_REGAD: begin
          regad_nxt = {regad[3:0], bit_in};
          if (cnt == 4'd0) begin
            // Read data is frozen here so later host writes cannot disturb it.
            shreg_nxt = regs[regad_nxt];
            state_nxt = (phyad != PHY_ADDR) ? S_IDLE : S_TA1;
          end else begin
            cnt_nxt = cnt - 4'd1;
          end
        end
        S_TA1: begin
          if (op_rd) begin
            mdio_o_nxt = 1'b0;
            mdio_t_nxt = 1'b0;
          end
          state_nxt = S_TA2;
        end
        S_TA2: begin
          if (op_rd) begin
            mdio_o_nxt = shreg[15];
            shreg_nxt  = {shreg[14:0], 1'b0};
          end
          cnt_nxt   = 4'd15;
          state_nxt = S_DATA;
        end
        S_DATA: begin
          if (op_rd) begin
            if (cnt == 4'd0) begin
              mdio_o_nxt = 1'b1;
              mdio_t_nxt = 1'b1;
              state_nxt  = S_IDLE;
            end else begin
              mdio_o_nxt = shreg[15];
              shreg_nxt  = {shreg[14:0], 1'b0};
              cnt_nxt    = cnt - 4'd1;
            end
          end else begin
            shreg_nxt = {shreg[14:0], bit_in};
            if (cnt == 4'd0) begin
              // ID registers are read-only from the management bus.
              commit_c  = (regad != 5'd2) && (regad != 5'd3);
              state_nxt = S_IDLE;
            end else begin
              cnt_nxt = cnt - 4'd1;
            end
          end
        end
        default: state_nxt = S_IDLE;
      endcase
      // Preamble run length: restarts on a 0 in IDLE and on frame exit.
      if (state != S_IDLE && state_nxt == S_IDLE) pre_nxt = '0;
      else if (state == S_IDLE && !bit_in)        pre_nxt = '0;
      else if (bit_in && pre_cnt != PRE_MAX)      pre_nxt = pre_cnt + PW'(1);
    end
  end

  // FSM state, frame registers and registered pad drive / write notification.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      pre_cnt      <= '0;
      cnt          <= '0;
      op_hi        <= 1'b0;
      op_rd        <= 1'b0;
      phyad        <= '0;
      regad        <= '0;
      shreg        <= '0;
      bus.mdio_o   <= 1'b1;
      bus.mdio_t   <= 1'b1;
      bus.wr_valid <= 1'b0;
      bus.wr_addr  <= '0;
      bus.wr_data  <= '0;
    end else begin
      state        <= state_nxt;
      pre_cnt      <= pre_nxt;
      cnt          <= cnt_nxt;
      op_hi        <= op_hi_nxt;
      op_rd        <= op_rd_nxt;
      phyad        <= phyad_nxt;
      regad        <= regad_nxt;
      shreg        <= shreg_nxt;
      bus.mdio_o   <= mdio_o_nxt;
      bus.mdio_t   <= mdio_t_nxt;
      bus.wr_valid <= commit_c;
      if (commit_c) begin
        bus.wr_addr <= regad;
        bus.wr_data <= shreg_nxt;
      end
    end
  end

  // Register file; an MDIO commit overrides a same-cycle host write.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
      regs[2] <= ID1;
      regs[3] <= ID2;
    end else begin
      if (bus.cfg_we) regs[bus.cfg_addr] <= bus.cfg_wdata;
      if (commit_c)   regs[regad]        <= shreg_nxt;
    end
  end

endmodule

// File: tb/tb_mdio_responder.sv
// Bench for mdio_responder: bit-banged MDIO master, register model and
// write/read scoreboards.
module tb_mdio_responder;

  localparam logic [4:0]  PHY = 5'd1;
  localparam logic [15:0] ID1 = 16'h0000;
  localparam logic [15:0] ID2 = 16'h0000;

  typedef struct packed {
    logic [4:0]  addr;
    logic [15:0] data;
  } wr_exp_t;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;

  mdio_responder_if bus ();

  mdio_responder #(
    .PHY_ADDR(PHY), .PREAMBLE_LEN(32), .ID1(ID1), .ID2(ID2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  wr_exp_t     exp_wr[$];
  logic [15:0] exp_rd[$];
  logic [15:0] model[32];
  logic        wr_q = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) model[i] = 16'h0000;
    model[2] = ID1;
    model[3] = ID2;
  endtask

  // Write-notification monitor: pops the scoreboard on every pulse.
  always @(negedge clk) begin
    if (bus.wr_valid) begin
      if (wr_q) check_eq("wr_pulse_len", 32'd2, 32'd1);
      if (exp_wr.size() == 0) begin
        check_eq("wr_unexpected", 32'd1, 32'd0);
      end else begin
        wr_exp_t e;
        e = exp_wr.pop_front();
        check_eq("wr_addr", 32'(bus.wr_addr), 32'(e.addr));
        check_eq("wr_data", 32'(bus.wr_data), 32'(e.data));
      end
    end
    wr_q = bus.wr_valid;
  end

  // One mdc period: low phase (sample pad at its end), then high phase.
  // cfg_hit pulses cfg_we on the clk in which the responder acts on this rise.
  task automatic mdc_bit(input logic b, input logic cfg_hit, output logic o, output logic t);
    bus.mdio_i = b;
    bus.mdc    = 1'b0;
    repeat (5) @(negedge clk);
    o = bus.mdio_o;
    t = bus.mdio_t;
    bus.mdc = 1'b1;
    if (cfg_hit) begin
      repeat (2) @(negedge clk);
      bus.cfg_we = 1'b1;
      @(negedge clk);
      bus.cfg_we = 1'b0;
      repeat (2) @(negedge clk);
    end else begin
      repeat (5) @(negedge clk);
    end
  endtask

  // Full frame; abort_j >= 0 pulses rst during the low phase of bit abort_j.
  task automatic frame(input int pre_len, input logic rd, input logic [4:0] phy,
                       input logic [4:0] ra, input logic [15:0] wdata,
                       input int abort_j, input logic conflict,
                       output logic [15:0] rdata, output logic ta1_t,
                       output logic [1:0] ta2_ot, output logic drv_all,
                       output logic end_t, output logic saw_drive);
    logic [31:0] fb;
    logic        o, t;
    fb = {2'b01, (rd ? 2'b10 : 2'b01), phy, ra, (rd ? 2'b11 : 2'b10),
          (rd ? 16'hFFFF : wdata)};
    saw_drive = 1'b0;
    drv_all   = 1'b1;
    rdata     = '0;
    ta1_t     = 1'b0;
    ta2_ot    = 2'b11;
    end_t     = 1'b0;
    for (int i = 0; i < pre_len; i++) begin
      mdc_bit(1'b1, 1'b0, o, t);
      if (!t) saw_drive = 1'b1;
    end
    for (int j = 0; j < 32; j++) begin
      if (j == abort_j) begin
        bus.mdio_i = 1'b1;
        bus.mdc    = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("rst_pre_t", 32'(bus.mdio_t), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check_eq("rst_mdio_t", 32'(bus.mdio_t), 32'd1);
        check_eq("rst_wr_valid", 32'(bus.wr_valid), 32'd0);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        return;
      end
      mdc_bit(fb[31-j], (conflict && j == 31), o, t);
      if (!t) saw_drive = 1'b1;
      if (j == 14) ta1_t = t;
      if (j == 15) ta2_ot = {o, t};
      if (j >= 15 && t) drv_all = 1'b0;
      if (j >= 16) rdata[31-j] = o;
    end
    bus.mdio_i = 1'b1;
    bus.mdc    = 1'b0;
    repeat (5) @(negedge clk);
    end_t = bus.mdio_t;
    if (!end_t) saw_drive = 1'b1;
  endtask

  task automatic do_read(input int pre_len, input logic [4:0] phy, input logic [4:0] ra,
                         input logic respond, input string tag);
    logic [15:0] rdata;
    logic [1:0]  ta2;
    logic        ta1_t, drv_all, end_t, saw;
    if (respond) exp_rd.push_back(model[ra]);
    frame(pre_len, 1'b1, phy, ra, 16'h0, -1, 1'b0, rdata, ta1_t, ta2, drv_all, end_t, saw);
    if (respond) begin
      check_eq({tag, "_ta1_t"}, 32'(ta1_t), 32'd1);
      check_eq({tag, "_ta2"}, 32'(ta2), 32'd0);
      check_eq({tag, "_drive"}, 32'(drv_all), 32'd1);
      check_eq({tag, "_data"}, 32'(rdata), 32'(exp_rd.pop_front()));
      check_eq({tag, "_release"}, 32'(end_t), 32'd1);
    end else begin
      check_eq({tag, "_no_drive"}, 32'(saw), 32'd0);
    end
  endtask

  task automatic do_write(input logic [4:0] phy, input logic [4:0] ra, input logic [15:0] d,
                          input logic conflict, input string tag);
    logic [15:0] rdata;
    logic [1:0]  ta2;
    logic        ta1_t, drv_all, end_t, saw;
    if (conflict) model[bus.cfg_addr] = bus.cfg_wdata;
    if (phy == PHY && ra != 5'd2 && ra != 5'd3) begin
      exp_wr.push_back('{addr: ra, data: d});
      model[ra] = d;
    end
    frame(32, 1'b0, phy, ra, d, -1, conflict, rdata, ta1_t, ta2, drv_all, end_t, saw);
    repeat (3) @(negedge clk);
    check_eq({tag, "_no_drive"}, 32'(saw), 32'd0);
  endtask

  initial begin
    logic [15:0] rd_unused;
    logic [1:0]  ta2_unused;
    logic        f1, f2, f3, f4;
    rst           = 1'b1;
    bus.mdc       = 1'b0;
    bus.mdio_i    = 1'b1;
    bus.cfg_we    = 1'b0;
    bus.cfg_addr  = '0;
    bus.cfg_wdata = '0;
    model_reset();
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_eq("rst_mdio_t", 32'(bus.mdio_t), 32'd1);
    check_eq("rst_mdio_o", 32'(bus.mdio_o), 32'd1);
    check_eq("rst_wr_valid", 32'(bus.wr_valid), 32'd0);
    check_eq("rst_wr_addr", 32'(bus.wr_addr), 32'd0);
    check_eq("rst_wr_data", 32'(bus.wr_data), 32'd0);

    do_read(32, PHY, 5'd2, 1'b1, "read_id1");

    do_write(PHY, 5'd4, 16'hA5C3, 1'b0, "write_r4");
    do_read(32, PHY, 5'd4, 1'b1, "read_r4");

    do_write(5'd5, 5'd4, 16'h1234, 1'b0, "wrong_phy");
    do_read(32, PHY, 5'd4, 1'b1, "read_r4_kept");

    do_write(PHY, 5'd3, 16'hBEEF, 1'b0, "write_id2");
    do_read(32, PHY, 5'd3, 1'b1, "read_id2");

    do_read(31, PHY, 5'd2, 1'b0, "short_pre");
    do_read(32, PHY, 5'd2, 1'b1, "after_short");

    bus.cfg_addr  = 5'd7;
    bus.cfg_wdata = 16'h00FF;
    bus.cfg_we    = 1'b1;
    @(negedge clk);
    bus.cfg_we    = 1'b0;
    model[7] = 16'h00FF;
    do_read(32, PHY, 5'd7, 1'b1, "cfg_r7");

    bus.cfg_addr  = 5'd7;
    bus.cfg_wdata = 16'h1111;
    do_write(PHY, 5'd7, 16'h2222, 1'b1, "conflict");
    do_read(32, PHY, 5'd7, 1'b1, "conflict_r7");

    bus.cfg_addr  = 5'd9;
    bus.cfg_wdata = 16'h5A5A;
    bus.cfg_we    = 1'b1;
    @(negedge clk);
    bus.cfg_we    = 1'b0;
    model[9] = 16'h5A5A;
    do_read(32, PHY, 5'd9, 1'b1, "cfg_r9");

    // Reset while the responder drives D8 of a read of register 9.
    frame(32, 1'b1, PHY, 5'd9, 16'h0, 23, 1'b0, rd_unused, f1, ta2_unused, f2, f3, f4);
    model_reset();
    do_read(32, PHY, 5'd9, 1'b1, "post_rst_r9");
    do_read(32, PHY, 5'd2, 1'b1, "post_rst_id1");

    repeat (10) @(negedge clk);
    check_eq("wr_pending", 32'(exp_wr.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
